// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle (no WSTRB/PROT/RRESP) shared by the register-file slave and its master.
interface axi4_lite_slave_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave holding NUM_REGS word registers, exported in parallel on regs_out.
// Independent write and read FSMs, one outstanding transaction each.
//
//   state  | meaning
//   W_IDLE | ready for AW and W
//   W_ADDR | address held, waiting for write data
//   W_DATA | data held, waiting for write address
//   W_RESP | response valid, waiting for bready
//   R_IDLE | ready for AR
//   R_DATA | read data valid, waiting for rready
module axi4_lite_slave_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi4_lite_slave_regfile_if.slave       bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDXW  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS * BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  do_commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [IDXW-1:0]       c_idx;
  logic                  c_ok;
  logic [IDXW-1:0]       r_idx;
  logic                  r_ok;

  assign bus.awready = (w_state == W_IDLE) || (w_state == W_DATA);
  assign bus.wready  = (w_state == W_IDLE) || (w_state == W_ADDR);
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = (r_state == R_IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  // Commit address/data come from the bus or from whichever half was parked earlier.
  always_comb begin
    do_commit = 1'b0;
    c_addr    = bus.awaddr;
    c_data    = bus.wdata;
    case (w_state)
      W_IDLE: do_commit = aw_hs && w_hs;
      W_ADDR: begin
        do_commit = w_hs;
        c_addr    = awaddr_q;
      end
      W_DATA: begin
        do_commit = aw_hs;
        c_data    = wdata_q;
      end
      default: do_commit = 1'b0;
    endcase
  end

  assign c_idx = c_addr[OFF +: IDXW];
  assign c_ok  = (c_addr < LIMIT);
  assign r_idx = bus.araddr[OFF +: IDXW];
  assign r_ok  = (bus.araddr < LIMIT);

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state  <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (do_commit) begin
      if (c_ok) regs[c_idx] <= c_data;
      bresp_q  <= c_ok ? RESP_OKAY : RESP_SLVERR;
      bvalid_q <= 1'b1;
      w_state  <= W_RESP;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q <= bus.awaddr;
            w_state  <= W_ADDR;
          end else if (w_hs) begin
            wdata_q <= bus.wdata;
            w_state <= W_DATA;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Register reads here see pre-edge contents, so a same-edge write returns the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.arvalid) begin
            rdata_q  <= r_ok ? regs[r_idx] : '0;
            rvalid_q <= 1'b1;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end
endmodule
